chebyshev_recurrence: RTL

- Sequential generator of Chebyshev polynomial terms T_0(x)..T_N(x) in signed fixed point, using T_{k+1} = 2·x·T_k − T_{k−1}.
- Sits directly upstream of chebyshev_saturation: each emitted WL-bit term feeds that stage's data_in, which clamps it.
- Terms are produced one at a time over a valid/ready stream with backpressure.

---
 rtl/chebyshev_pkg.sv | 33 +++
 rtl/chebyshev_step.sv | 59 +++++
 rtl/chebyshev_recurrence.sv | 99 +++++++++
 3 files changed

// File: rtl/chebyshev_pkg.sv
// Shared definitions for the Chebyshev term generator and its saturation stage.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package chebyshev_pkg;

  // Generator FSM: IDLE waits for start, EMIT presents a term, CALC computes the next one.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_CALC = 2'd2
  } state_t;

  // Fractional bits of the Q(I).(F) format.
  function automatic int f_bits(input int wl, input int i_bits);
    return wl - i_bits;
  endfunction

  // Fixed-point 1.0, i.e. 1 << F_BITS.
  function automatic longint fx_one(input int wl, input int i_bits);
    return longint'(1) << (wl - i_bits);
  endfunction

  // Largest representable two's-complement value of a wl-bit word.
  function automatic longint sat_max(input int wl);
    return (longint'(1) << (wl - 1)) - 1;
  endfunction

  // Smallest representable two's-complement value of a wl-bit word.
  function automatic longint sat_min(input int wl);
    return -(longint'(1) << (wl - 1));
  endfunction

endpackage

// File: rtl/chebyshev_step.sv
// One recurrence step T_next = 2*x*T_cur - T_prev in signed fixed point.
// Latency: combinational. Backpressure: none (pure datapath).
// Build option CHEB_REC_SAT_EN: clamp the result to the word range instead of wrapping.
module chebyshev_step
  import chebyshev_pkg::*;
#(
  parameter int WL     = 12,
  parameter int I_BITS = 6
) (
  input  logic [WL-1:0] x_i,
  input  logic [WL-1:0] t_cur_i,
  input  logic [WL-1:0] t_prev_i,
  output logic [WL-1:0] t_next_o
);

  localparam int F_BITS = f_bits(WL, I_BITS);
  // Shifting by F_BITS-1 instead of F_BITS folds in the factor of 2.
  localparam int SHIFT  = F_BITS - 1;

  logic signed [2*WL-1:0] x_ext;
  logic signed [2*WL-1:0] t_cur_ext;
  logic signed [2*WL-1:0] prod;
  logic signed [2*WL-1:0] scaled;
  logic signed [2*WL:0]   diff;

  // Full-precision product, flooring rescale, and one extra bit for the subtraction.
  always_comb begin
    x_ext     = {{WL{x_i[WL-1]}}, x_i};
    t_cur_ext = {{WL{t_cur_i[WL-1]}}, t_cur_i};
    prod      = x_ext * t_cur_ext;
    scaled    = prod >>> SHIFT;
    diff      = {scaled[2*WL-1], scaled} - {{(WL+1){t_prev_i[WL-1]}}, t_prev_i};
  end

`ifdef CHEB_REC_SAT_EN
  localparam logic signed [2*WL:0] D_MAX = (2*WL+1)'(sat_max(WL));
  localparam logic signed [2*WL:0] D_MIN = (2*WL+1)'(sat_min(WL));

  // Clamp into the representable range; the clamped value feeds later terms.
  always_comb begin
    t_next_o = diff[WL-1:0];
    if (diff > D_MAX) begin
      t_next_o = D_MAX[WL-1:0];
    end else if (diff < D_MIN) begin
      t_next_o = D_MIN[WL-1:0];
    end
  end
`else
  // Upper bits are intentionally discarded by the two's-complement wrap.
  logic unused_diff_hi;
  assign unused_diff_hi = ^diff[2*WL:WL];

  // Wrap: keep the low WL bits; wrapped values propagate into later terms.
  always_comb begin
    t_next_o = diff[WL-1:0];
  end
`endif

endmodule

// File: rtl/chebyshev_recurrence.sv
// Streams Chebyshev terms T_0(x)..T_N(x) one per handshake via T_{k+1} = 2x*T_k - T_{k-1}.
// Latency: T_0 one cycle after start, T_1 one cycle after the T_0 handshake, later terms two cycles after the previous handshake.
// Backpressure: outputs hold while out_valid && !out_ready; start is only taken in IDLE. Build option CHEB_REC_SAT_EN selects clamping.
module chebyshev_recurrence
  import chebyshev_pkg::*;
#(
  parameter int WL      = 12,
  parameter int I_BITS  = 6,
  parameter int ORDER_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               start_ready,
  input  logic [WL-1:0]      x_in,
  input  logic [ORDER_W-1:0] order,
  output logic [WL-1:0]      out_data,
  output logic [ORDER_W-1:0] out_index,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last
);

  localparam logic [WL-1:0] ONE = WL'(fx_one(WL, I_BITS));

  state_t             state_q;
  logic [WL-1:0]      x_q;
  logic [WL-1:0]      t_prev_q;
  logic [WL-1:0]      t_cur_q;
  logic [ORDER_W-1:0] k_q;
  logic [ORDER_W-1:0] n_q;
  logic [WL-1:0]      t_next_d;

  chebyshev_step #(
    .WL     (WL),
    .I_BITS (I_BITS)
  ) u_step (
    .x_i      (x_q),
    .t_cur_i  (t_cur_q),
    .t_prev_i (t_prev_q),
    .t_next_o (t_next_d)
  );

  // Sequencer: latch the job, present each term until accepted, compute the next in CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      t_prev_q <= '0;
      t_cur_q  <= '0;
      k_q      <= '0;
      n_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            x_q      <= x_in;
            n_q      <= order;
            t_prev_q <= '0;
            t_cur_q  <= ONE;
            k_q      <= '0;
            state_q  <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (k_q == n_q) begin
              state_q <= ST_IDLE;
            end else if (k_q == '0) begin
              // T_1 = x needs no arithmetic, so skip the CALC cycle.
              t_prev_q <= t_cur_q;
              t_cur_q  <= x_q;
              k_q      <= k_q + 1'b1;
            end else begin
              state_q <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          t_prev_q <= t_cur_q;
          t_cur_q  <= t_next_d;
          k_q      <= k_q + 1'b1;
          state_q  <= ST_EMIT;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs come straight from registers, so they are stable for a whole stall.
  assign start_ready = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_EMIT);
  assign out_data    = t_cur_q;
  assign out_index   = k_q;
  assign out_last    = (state_q == ST_EMIT) && (k_q == n_q);

endmodule
